// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
//   Shared definitions for the router packet source.
//   - tx_state_e   : transmitter FSM states
//   - ADDR_ILLEGAL : destination code that has no router output port
//   - pack_hdr()   : builds the header byte {len, addr}
// -----------------------------------------------------------------------------
package router_pkg;

   localparam int HDR_LEN_W  = 6;
   localparam int HDR_ADDR_W = 2;

   localparam logic [HDR_ADDR_W-1:0] ADDR_ILLEGAL = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COLLECT = 3'd1,
      ST_HEADER  = 3'd2,
      ST_PAYLOAD = 3'd3,
      ST_PARITY  = 3'd4,
      ST_GAP     = 3'd5
   } tx_state_e;

   function automatic logic [HDR_LEN_W+HDR_ADDR_W-1:0] pack_hdr(
      input logic [HDR_LEN_W-1:0]  len,
      input logic [HDR_ADDR_W-1:0] addr
   );
      return {len, addr};
   endfunction

endpackage

// File: rtl/router_tx_buf.sv
// -----------------------------------------------------------------------------
// router_tx_buf
//   Payload store for one packet: 1 write / 1 read register array.
//   Synchronous write, asynchronous read. Contents are not reset.
// Ports:
//   clk      in   clock
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   raddr_i  in   read address
//   rdata_o  out  read data (combinational from raddr_i)
// -----------------------------------------------------------------------------
module router_tx_buf #(
   parameter int DATA_W = 8,
   parameter int AW     = 6
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [2**AW];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/router_pkt_tx.sv
// -----------------------------------------------------------------------------
// router_pkt_tx
//   Store-and-forward packet source for the 1x3 router input port.
//   A command {addr,len} is accepted, len payload bytes are collected into a
//   local buffer, then header {len,addr}, payload and an XOR parity byte are
//   sent back-to-back so pkt_valid never drops inside a packet.
//   All outputs are registered.
// Optional build macro:
//   ROUTER_TX_STATS_EN : adds saturating 16-bit counters pkt_cnt, err_cnt,
//                        rej_cnt (reset to 0).
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   cmd_valid/ready     command handshake; cmd_addr, cmd_len command fields
//   cmd_err             1-cycle pulse, command rejected (illegal addr)
//   pl_valid/ready      payload byte handshake; pl_data payload byte
//   pkt_valid, data_out router input; byte held while busy=1
//   busy, err           router flow control and parity error flag
//   tx_busy             FSM not idle
//   tx_done             1-cycle pulse after the parity byte is accepted
//   err_seen            1-cycle pulse, err seen during the gap (once per pkt)
// -----------------------------------------------------------------------------
module router_pkt_tx
   import router_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int LEN_W      = 6,
   parameter int GAP_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   output logic              cmd_err,
   input  logic              pl_valid,
   output logic              pl_ready,
   input  logic [DATA_W-1:0] pl_data,
   output logic              pkt_valid,
   output logic [DATA_W-1:0] data_out,
   input  logic              busy,
   input  logic              err,
   output logic              tx_busy,
   output logic              tx_done,
   output logic              err_seen
`ifdef ROUTER_TX_STATS_EN
   ,
   output logic [15:0]       pkt_cnt,
   output logic [15:0]       err_cnt,
   output logic [15:0]       rej_cnt
`endif
);

   localparam int GAP_W = $clog2(GAP_CYCLES) + 1;

   tx_state_e         state_q, state_d;
   logic [1:0]        addr_q, addr_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [LEN_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0] par_q, par_d;
   logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
   logic              err_flag_q, err_flag_d;

   logic              cmd_ready_q, cmd_ready_d;
   logic              pl_ready_q, pl_ready_d;
   logic              pkt_valid_q, pkt_valid_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic              cmd_err_q, cmd_err_d;
   logic              tx_done_q, tx_done_d;
   logic              err_seen_q, err_seen_d;
   logic              tx_busy_q, tx_busy_d;

   logic              buf_we;
   logic [DATA_W-1:0] buf_rdata;
   logic              cmd_hs, pl_hs, xfer;

   // Handshakes are qualified by the registered ready outputs the peer sees.
   assign cmd_hs = cmd_valid & cmd_ready_q;
   assign pl_hs  = pl_valid & pl_ready_q;
   assign xfer   = ~busy;

   router_tx_buf #(
      .DATA_W (DATA_W),
      .AW     (LEN_W)
   ) u_buf (
      .clk     (clk),
      .we_i    (buf_we),
      .waddr_i (wr_ptr_q),
      .wdata_i (pl_data),
      .raddr_i (rd_ptr_d),
      .rdata_o (buf_rdata)
   );

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      len_d      = len_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      par_d      = par_q;
      gap_cnt_d  = gap_cnt_q;
      err_flag_d = err_flag_q;
      cmd_err_d  = 1'b0;
      tx_done_d  = 1'b0;
      err_seen_d = 1'b0;
      buf_we     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cmd_hs) begin
               if (cmd_addr == ADDR_ILLEGAL) begin
                  cmd_err_d = 1'b1;
               end else begin
                  addr_d   = cmd_addr;
                  len_d    = cmd_len;
                  par_d    = pack_hdr(cmd_len, cmd_addr);
                  wr_ptr_d = '0;
                  rd_ptr_d = '0;
                  state_d  = (cmd_len == '0) ? ST_HEADER : ST_COLLECT;
               end
            end
         end
         ST_COLLECT: begin
            if (pl_hs) begin
               buf_we   = 1'b1;
               wr_ptr_d = wr_ptr_q + LEN_W'(1);
               par_d    = par_q ^ pl_data;
               if (wr_ptr_q == len_q - LEN_W'(1)) state_d = ST_HEADER;
            end
         end
         ST_HEADER: begin
            if (xfer) state_d = (len_q == '0) ? ST_PARITY : ST_PAYLOAD;
         end
         ST_PAYLOAD: begin
            if (xfer) begin
               rd_ptr_d = rd_ptr_q + LEN_W'(1);
               if (rd_ptr_q == len_q - LEN_W'(1)) state_d = ST_PARITY;
            end
         end
         ST_PARITY: begin
            if (xfer) begin
               state_d    = ST_GAP;
               tx_done_d  = 1'b1;
               gap_cnt_d  = GAP_W'(GAP_CYCLES - 1);
               err_flag_d = 1'b0;
            end
         end
         ST_GAP: begin
            // err_flag limits the report to one pulse per packet.
            if (err && !err_flag_q) begin
               err_seen_d = 1'b1;
               err_flag_d = 1'b1;
            end
            if (gap_cnt_q == '0) state_d = ST_IDLE;
            else                 gap_cnt_d = gap_cnt_q - GAP_W'(1);
         end
         default: state_d = ST_IDLE;
      endcase

      // Outputs follow the next state so the registered copies line up with
      // the state register. Under busy nothing changes, so the byte holds.
      cmd_ready_d = (state_d == ST_IDLE);
      pl_ready_d  = (state_d == ST_COLLECT);
      pkt_valid_d = (state_d == ST_HEADER) || (state_d == ST_PAYLOAD);
      tx_busy_d   = (state_d != ST_IDLE);
      case (state_d)
         ST_HEADER:  data_out_d = pack_hdr(len_d, addr_d);
         ST_PAYLOAD: data_out_d = buf_rdata;
         ST_PARITY:  data_out_d = par_d;
         default:    data_out_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         len_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         par_q       <= '0;
         gap_cnt_q   <= '0;
         err_flag_q  <= 1'b0;
         cmd_ready_q <= 1'b0;
         pl_ready_q  <= 1'b0;
         pkt_valid_q <= 1'b0;
         data_out_q  <= '0;
         cmd_err_q   <= 1'b0;
         tx_done_q   <= 1'b0;
         err_seen_q  <= 1'b0;
         tx_busy_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         par_q       <= par_d;
         gap_cnt_q   <= gap_cnt_d;
         err_flag_q  <= err_flag_d;
         cmd_ready_q <= cmd_ready_d;
         pl_ready_q  <= pl_ready_d;
         pkt_valid_q <= pkt_valid_d;
         data_out_q  <= data_out_d;
         cmd_err_q   <= cmd_err_d;
         tx_done_q   <= tx_done_d;
         err_seen_q  <= err_seen_d;
         tx_busy_q   <= tx_busy_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign pl_ready  = pl_ready_q;
   assign pkt_valid = pkt_valid_q;
   assign data_out  = data_out_q;
   assign cmd_err   = cmd_err_q;
   assign tx_done   = tx_done_q;
   assign err_seen  = err_seen_q;
   assign tx_busy   = tx_busy_q;

`ifdef ROUTER_TX_STATS_EN
   logic [15:0] pkt_cnt_q, err_cnt_q, rej_cnt_q;

   // Counters advance on the registered pulses and stick at all-ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         pkt_cnt_q <= '0;
         err_cnt_q <= '0;
         rej_cnt_q <= '0;
      end else begin
         if (tx_done_q  && pkt_cnt_q != 16'hFFFF) pkt_cnt_q <= pkt_cnt_q + 16'd1;
         if (err_seen_q && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
         if (cmd_err_q  && rej_cnt_q != 16'hFFFF) rej_cnt_q <= rej_cnt_q + 16'd1;
      end
   end

   assign pkt_cnt = pkt_cnt_q;
   assign err_cnt = err_cnt_q;
   assign rej_cnt = rej_cnt_q;
`endif

endmodule

// File: tb/tb_router_pkt_tx.sv
// -----------------------------------------------------------------------------
// tb_router_pkt_tx
//   Directed bench for router_pkt_tx. Inputs change 1 time unit after the
//   rising edge; outputs are sampled at that same point, away from the edge.
//   Header byte is {len,addr}; parity is the XOR of header and payload.
// -----------------------------------------------------------------------------
module tb_router_pkt_tx;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_addr = '0;
   logic [5:0] cmd_len = '0;
   logic       cmd_err;
   logic       pl_valid = 1'b0;
   logic       pl_ready;
   logic [7:0] pl_data = '0;
   logic       pkt_valid;
   logic [7:0] data_out;
   logic       busy = 1'b0;
   logic       err = 1'b0;
   logic       tx_busy;
   logic       tx_done;
   logic       err_seen;
`ifdef ROUTER_TX_STATS_EN
   logic [15:0] pkt_cnt, err_cnt, rej_cnt;
`endif

   int vecs = 0;
   int miscmp = 0;

   router_pkt_tx dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_addr  (cmd_addr),
      .cmd_len   (cmd_len),
      .cmd_err   (cmd_err),
      .pl_valid  (pl_valid),
      .pl_ready  (pl_ready),
      .pl_data   (pl_data),
      .pkt_valid (pkt_valid),
      .data_out  (data_out),
      .busy      (busy),
      .err       (err),
      .tx_busy   (tx_busy),
      .tx_done   (tx_done),
      .err_seen  (err_seen)
`ifdef ROUTER_TX_STATS_EN
      ,
      .pkt_cnt   (pkt_cnt),
      .err_cnt   (err_cnt),
      .rej_cnt   (rej_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vecs++;
      assert (obs === exp)
      else begin
         miscmp++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic pv, input logic [7:0] d);
      chk(tag, {7'd0, pkt_valid, data_out}, {7'd0, pv, d});
   endtask

   task automatic send_cmd(input logic [1:0] a, input logic [5:0] l);
      int n;
      cmd_valid = 1'b1;
      cmd_addr  = a;
      cmd_len   = l;
      n = 0;
      while (!cmd_ready && n < 50) begin
         step();
         n++;
      end
      if (!cmd_ready) chk("cmd_ready_timeout", {15'd0, cmd_ready}, 16'd1);
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic push(input logic [7:0] d);
      int n;
      pl_valid = 1'b1;
      pl_data  = d;
      n = 0;
      while (!pl_ready && n < 50) begin
         step();
         n++;
      end
      if (!pl_ready) chk("pl_ready_timeout", {15'd0, pl_ready}, 16'd1);
      step();
      pl_valid = 1'b0;
   endtask

   function automatic logic [7:0] t4_byte(input int i);
      return 8'((i * 37 + 5) & 255);
   endfunction

   initial begin
      logic [7:0] par4;
      int         hi;

      // ---- reset state ----
      step(3);
      chk("rst_out",  {8'd0, pkt_valid, data_out[6:0]}, 16'd0);
      chk("rst_ctl",  {10'd0, cmd_ready, pl_ready, cmd_err, tx_done, err_seen, tx_busy}, 16'd0);
      reset = 1'b0;
      step();
      chk("rdy_after_rst", {14'd0, cmd_ready, tx_busy}, 16'b10);

      // ---- 1: addr=1 len=3, no backpressure: 0D A5 3C 0F 9B ----
      send_cmd(2'd1, 6'd3);
      chk("t1_collect", {14'd0, pl_ready, cmd_ready}, 16'b10);
      push(8'hA5); push(8'h3C); push(8'h0F);
      chk("t1_pl_ready_drop", {15'd0, pl_ready}, 16'd0);
      chk_out("t1_hdr", 1'b1, 8'h0D); step();
      chk_out("t1_b0",  1'b1, 8'hA5); step();
      chk_out("t1_b1",  1'b1, 8'h3C); step();
      chk_out("t1_b2",  1'b1, 8'h0F); step();
      chk_out("t1_par", 1'b0, 8'h9B);
      chk("t1_done_early", {15'd0, tx_done}, 16'd0);
      step();
      chk("t1_done", {7'd0, tx_done, data_out}, {7'd0, 1'b1, 8'h00});
      step();
      chk("t1_gap2", {14'd0, tx_done, cmd_ready}, 16'b00);
      step();
      chk("t1_idle", {14'd0, cmd_ready, tx_busy}, 16'b10);

      // ---- 2: same packet, busy held 4 cycles on 3C ----
      send_cmd(2'd1, 6'd3);
      push(8'hA5); push(8'h3C); push(8'h0F);
      chk_out("t2_hdr", 1'b1, 8'h0D); step();
      chk_out("t2_b0",  1'b1, 8'hA5); step();
      busy = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk_out("t2_hold", 1'b1, 8'h3C);
         step();
      end
      busy = 1'b0;
      chk_out("t2_hold_last", 1'b1, 8'h3C); step();
      chk_out("t2_b2",  1'b1, 8'h0F); step();
      chk_out("t2_par", 1'b0, 8'h9B); step();
      chk("t2_done", {15'd0, tx_done}, 16'd1);
      step(2);

      // ---- 3: illegal addr rejected, then zero-length packet ----
      pl_valid = 1'b1;
      pl_data  = 8'h55;
      send_cmd(2'd3, 6'd5);
      chk("t3_rej", {12'd0, cmd_err, pl_ready, pkt_valid, cmd_ready}, 16'b1001);
      chk("t3_rej_busy", {15'd0, tx_busy}, 16'd0);
      step();
      chk("t3_err_pulse", {14'd0, cmd_err, pl_ready}, 16'b00);
      pl_valid = 1'b0;
      send_cmd(2'd0, 6'd0);
      chk_out("t3_hdr", 1'b1, 8'h00); step();
      chk_out("t3_par", 1'b0, 8'h00); step();
      chk("t3_done", {15'd0, tx_done}, 16'd1);
      step(2);

      // ---- 4: addr=2 len=63, pl_valid toggling, err in gap ----
      send_cmd(2'd2, 6'd63);
      par4 = 8'hFE;
      for (int i = 0; i < 63; i++) begin
         pl_valid = 1'b0;
         step();
         push(t4_byte(i));
         par4 = par4 ^ t4_byte(i);
      end
      hi = 0;
      chk_out("t4_hdr", 1'b1, 8'hFE);
      for (int k = 0; k < 64; k++) begin
         if (pkt_valid) hi++;
         if (k > 0 && data_out !== t4_byte(k - 1)) chk("t4_byte", {8'd0, data_out}, {8'd0, t4_byte(k - 1)});
         step();
      end
      chk("t4_contig", 16'(hi), 16'd64);
      chk_out("t4_par", 1'b0, par4);
      step();
      chk("t4_done", {15'd0, tx_done}, 16'd1);
      err = 1'b1;
      step();
      chk("t4_err_seen", {15'd0, err_seen}, 16'd1);
      step();
      chk("t4_err_once", {14'd0, err_seen, cmd_ready}, 16'b01);
      err = 1'b0;

`ifdef ROUTER_TX_STATS_EN
      step();
      chk("st_pkt", pkt_cnt, 16'd4);
      chk("st_rej", rej_cnt, 16'd1);
      chk("st_err", err_cnt, 16'd1);
`endif

      // ---- 5: reset during payload byte 2, then a fresh packet ----
      send_cmd(2'd1, 6'd3);
      push(8'hA5); push(8'h3C); push(8'h0F);
      step(2);
      chk_out("t5_b1", 1'b1, 8'h3C);
      reset = 1'b1;
      step();
      chk("t5_rst_out", {7'd0, pkt_valid, data_out}, 16'd0);
      chk("t5_rst_ctl", {10'd0, cmd_ready, pl_ready, cmd_err, tx_done, err_seen, tx_busy}, 16'd0);
      reset = 1'b0;
      step();
      chk("t5_rdy", {15'd0, cmd_ready}, 16'd1);
`ifdef ROUTER_TX_STATS_EN
      chk("st_rst", pkt_cnt | err_cnt | rej_cnt, 16'd0);
`endif
      send_cmd(2'd2, 6'd2);
      push(8'h11); push(8'h22);
      chk_out("t5_hdr", 1'b1, 8'h0A); step();
      chk_out("t5_b0",  1'b1, 8'h11); step();
      chk_out("t5_b1n", 1'b1, 8'h22); step();
      chk_out("t5_par", 1'b0, 8'h39); step();
      chk("t5_done", {15'd0, tx_done}, 16'd1);
      step();
`ifdef ROUTER_TX_STATS_EN
      chk("st_pkt_after", pkt_cnt, 16'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
      $finish;
   end

endmodule
